// File: rtl/idecode_regfile_sb_if.sv
// Decode-stage register file / writeback bus.
// Signal names follow the Minisys Idecode32 port list.
interface idecode_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              use_rs;
  logic              use_rt;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [2:0]        wb_sel;
  logic              link_ra;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [OFF_W-1:0]  mem_byte_off;
  logic [DATA_W-1:0] link_addr;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] hi_wdata;
  logic [DATA_W-1:0] lo_wdata;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              load_issue;
  logic [ADDR_W-1:0] load_dest;
  logic              stall;
  logic [DATA_W-1:0] write_data_out;
  logic [ADDR_W-1:0] write_register_address_out;

  modport slave (
    input  rs_addr, rt_addr, use_rs, use_rt,
    input  wb_valid, wb_addr, wb_sel, link_ra,
    input  alu_result, mem_data, mem_size,
    input  mem_unsigned, mem_byte_off, link_addr,
    input  hi_we, lo_we, hi_wdata, lo_wdata,
    input  load_issue, load_dest,
    output read_data_1, read_data_2,
    output hi_out, lo_out, stall,
    output write_data_out, write_register_address_out
  );

  modport master (
    output rs_addr, rt_addr, use_rs, use_rt,
    output wb_valid, wb_addr, wb_sel, link_ra,
    output alu_result, mem_data, mem_size,
    output mem_unsigned, mem_byte_off, link_addr,
    output hi_we, lo_we, hi_wdata, lo_wdata,
    output load_issue, load_dest,
    input  read_data_1, read_data_2,
    input  hi_out, lo_out, stall,
    input  write_data_out, write_register_address_out
  );
endinterface

// File: rtl/idecode_regfile_sb.sv
// Register file, HI/LO, writeback mux, load extract, load-use scoreboard.
// Optional REGFILE_BYPASS_EN: write-to-read bypass and early stall release.
module idecode_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic clock,
  input  logic reset,
  idecode_regfile_sb_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int OFF_W    = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  localparam logic [2:0] SEL_ALU  = 3'd0;
  localparam logic [2:0] SEL_MEM  = 3'd1;
  localparam logic [2:0] SEL_LINK = 3'd2;
  localparam logic [2:0] SEL_HI   = 3'd3;
  localparam logic [2:0] SEL_LO   = 3'd4;

  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [NUM_REGS-1:0] busy_q, busy_d, busy_eff;
  logic [DATA_W-1:0]   wd_q;
  logic [ADDR_W-1:0]   wa_q;

  logic [DATA_W-1:0] hsh, bsh, ld_val, wdata;
  logic [ADDR_W-1:0] dest;
  logic              sx, commit, clr_mem;

  always_comb begin
    sx  = ~bus.mem_unsigned;
    hsh = bus.mem_data >> {bus.mem_byte_off[OFF_W-1:1], 4'b0000};
    bsh = bus.mem_data >> {bus.mem_byte_off, 3'b000};
    unique case (bus.mem_size)
      2'd1:    ld_val = {{(DATA_W-16){sx & hsh[15]}}, hsh[15:0]};
      2'd2:    ld_val = {{(DATA_W-8){sx & bsh[7]}}, bsh[7:0]};
      default: ld_val = bus.mem_data;
    endcase
  end

  always_comb begin
    dest = (bus.wb_sel == SEL_LINK && bus.link_ra) ? LINK_A : bus.wb_addr;
    unique case (bus.wb_sel)
      SEL_ALU:  wdata = bus.alu_result;
      SEL_MEM:  wdata = ld_val;
      SEL_LINK: wdata = bus.link_addr;
      SEL_HI:   wdata = hi_q;
      SEL_LO:   wdata = lo_q;
      default:  wdata = '0;
    endcase
    commit  = bus.wb_valid && (bus.wb_sel <= SEL_LO) && (dest != '0);
    clr_mem = commit && (bus.wb_sel == SEL_MEM);
  end

  // Set after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_mem)
      busy_d[dest] = 1'b0;
    if (bus.load_issue && bus.load_dest != '0)
      busy_d[bus.load_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_eff = busy_q;
`ifdef REGFILE_BYPASS_EN
    if (clr_mem)
      busy_eff[dest] = 1'b0;
`endif
  end

  assign bus.stall = (bus.use_rs & busy_eff[bus.rs_addr])
                   | (bus.use_rt & busy_eff[bus.rt_addr]);

  always_comb begin
    bus.read_data_1 = (bus.rs_addr == '0) ? '0 : rf_q[bus.rs_addr];
    bus.read_data_2 = (bus.rt_addr == '0) ? '0 : rf_q[bus.rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (commit && dest == bus.rs_addr)
      bus.read_data_1 = wdata;
    if (commit && dest == bus.rt_addr)
      bus.read_data_2 = wdata;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf_q[i] <= '0;
    end else if (commit) begin
      rf_q[dest] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= '0;
      wd_q   <= '0;
      wa_q   <= '0;
    end else begin
      if (bus.hi_we) hi_q <= bus.hi_wdata;
      if (bus.lo_we) lo_q <= bus.lo_wdata;
      busy_q <= busy_d;
      if (commit) begin
        wd_q <= wdata;
        wa_q <= dest;
      end
    end
  end

  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
  assign bus.write_data_out = wd_q;
  assign bus.write_register_address_out = wa_q;
endmodule

// File: tb/tb_idecode_regfile_sb.sv
// Directed bench for idecode_regfile_sb.
// Expected values are hand-derived constants.
module tb_idecode_regfile_sb;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  idecode_regfile_sb_if ifc ();

  idecode_regfile_sb dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wb(input logic [2:0] sel, input logic [4:0] addr,
                    input logic [31:0] alu);
    ifc.wb_valid   = 1'b1;
    ifc.wb_sel     = sel;
    ifc.wb_addr    = addr;
    ifc.alu_result = alu;
    step();
    ifc.wb_valid = 1'b0;
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns,
                    input logic [1:0] off, input logic [31:0] exp,
                    input string tag);
    ifc.mem_size     = sz;
    ifc.mem_unsigned = uns;
    ifc.mem_byte_off = off;
    wb(3'd1, 5'd4, 32'h0);
    ifc.rs_addr = 5'd4;
    #1;
    chk(tag, ifc.read_data_1, exp);
  endtask

  initial begin
    logic exp_st;
    logic [31:0] exp_rd;
`ifdef REGFILE_BYPASS_EN
    exp_st = 1'b0;
    exp_rd = 32'h1122_3344;
`else
    exp_st = 1'b1;
    exp_rd = 32'h0;
`endif
    ifc.rs_addr = '0; ifc.rt_addr = '0;
    ifc.use_rs = 0; ifc.use_rt = 0;
    ifc.wb_valid = 0; ifc.wb_addr = '0;
    ifc.wb_sel = '0; ifc.link_ra = 0;
    ifc.alu_result = '0; ifc.mem_data = '0;
    ifc.mem_size = '0; ifc.mem_unsigned = 0;
    ifc.mem_byte_off = '0; ifc.link_addr = '0;
    ifc.hi_we = 0; ifc.lo_we = 0;
    ifc.hi_wdata = '0; ifc.lo_wdata = '0;
    ifc.load_issue = 0; ifc.load_dest = '0;
    step();
    step();
    reset = 1'b0;

    ifc.rs_addr = 5'd5;
    ifc.rt_addr = 5'd31;
    #1;
    chk("rst_rd1", ifc.read_data_1, 32'h0);
    chk("rst_rd2", ifc.read_data_2, 32'h0);
    chk("rst_hi", ifc.hi_out, 32'h0);
    chk("rst_lo", ifc.lo_out, 32'h0);
    chk("rst_stall", {31'b0, ifc.stall}, 32'h0);
    chk("rst_wa", {27'b0, ifc.write_register_address_out}, 32'h0);

    wb(3'd0, 5'd3, 32'h1234_5678);
    ifc.rs_addr = 5'd3;
    #1;
    chk("alu_r3", ifc.read_data_1, 32'h1234_5678);
    chk("alu_wa", {27'b0, ifc.write_register_address_out}, 32'd3);
    chk("alu_wd", ifc.write_data_out, 32'h1234_5678);

    wb(3'd0, 5'd0, 32'hFFFF_FFFF);
    ifc.rs_addr = 5'd0;
    #1;
    chk("r0_rd", ifc.read_data_1, 32'h0);
    chk("r0_wa", {27'b0, ifc.write_register_address_out}, 32'd3);
    chk("r0_wd", ifc.write_data_out, 32'h1234_5678);

    ifc.mem_data = 32'h80FF_7F01;
    ld(2'd2, 1'b0, 2'd1, 32'h0000_007F, "lb_o1");
    ld(2'd2, 1'b0, 2'd3, 32'hFFFF_FF80, "lb_o3");
    ld(2'd2, 1'b1, 2'd3, 32'h0000_0080, "lbu_o3");
    ld(2'd1, 1'b0, 2'd2, 32'hFFFF_80FF, "lh_o2");
    ld(2'd1, 1'b1, 2'd0, 32'h0000_7F01, "lhu_o0");
    ld(2'd1, 1'b0, 2'd3, 32'hFFFF_80FF, "lh_o3");
    ld(2'd3, 1'b0, 2'd1, 32'h80FF_7F01, "lw_sz3");

    ifc.hi_we = 1; ifc.hi_wdata = 32'hAAAA_0001;
    ifc.lo_we = 1; ifc.lo_wdata = 32'h5555_0002;
    step();
    ifc.lo_we = 0;
    ifc.hi_wdata = 32'h0;
    chk("hi_wr", ifc.hi_out, 32'hAAAA_0001);
    chk("lo_wr", ifc.lo_out, 32'h5555_0002);
    wb(3'd3, 5'd6, 32'h0);
    ifc.hi_we = 0;
    ifc.rs_addr = 5'd6;
    #1;
    chk("mfhi_r6", ifc.read_data_1, 32'hAAAA_0001);
    chk("hi_new", ifc.hi_out, 32'h0);
    chk("lo_hold", ifc.lo_out, 32'h5555_0002);
    ifc.lo_we = 1; ifc.lo_wdata = 32'h1;
    wb(3'd4, 5'd8, 32'h0);
    ifc.lo_we = 0;
    ifc.rs_addr = 5'd8;
    #1;
    chk("mflo_r8", ifc.read_data_1, 32'h5555_0002);
    chk("lo_new", ifc.lo_out, 32'h1);

    ifc.link_addr = 32'h40;
    ifc.link_ra = 1;
    wb(3'd2, 5'd7, 32'h0);
    ifc.rs_addr = 5'd31;
    ifc.rt_addr = 5'd7;
    #1;
    chk("jal_r31", ifc.read_data_1, 32'h40);
    chk("jal_r7", ifc.read_data_2, 32'h0);
    chk("jal_wa", {27'b0, ifc.write_register_address_out}, 32'd31);
    ifc.link_ra = 0;
    wb(3'd2, 5'd7, 32'h0);
    #1;
    chk("jalr_r7", ifc.read_data_2, 32'h40);

    wb(3'd5, 5'd10, 32'hDEAD_BEEF);
    ifc.rs_addr = 5'd10;
    #1;
    chk("sel5_r10", ifc.read_data_1, 32'h0);
    chk("sel5_wa", {27'b0, ifc.write_register_address_out}, 32'd7);

    ifc.load_issue = 1; ifc.load_dest = 5'd9;
    step();
    ifc.load_issue = 0;
    ifc.rs_addr = 5'd9; ifc.use_rs = 1;
    ifc.rt_addr = 5'd0;
    #1;
    chk("st_rs", {31'b0, ifc.stall}, 32'd1);
    ifc.use_rs = 0;
    #1;
    chk("st_nouse", {31'b0, ifc.stall}, 32'd0);
    ifc.use_rt = 1; ifc.rt_addr = 5'd9;
    #1;
    chk("st_rt", {31'b0, ifc.stall}, 32'd1);
    ifc.use_rt = 0; ifc.use_rs = 1;
    reset = 1;
    step();
    reset = 0;
    #1;
    chk("st_rst", {31'b0, ifc.stall}, 32'd0);

    ifc.load_issue = 1; ifc.load_dest = 5'd0;
    step();
    ifc.load_issue = 0; ifc.rs_addr = 5'd0;
    #1;
    chk("st_r0", {31'b0, ifc.stall}, 32'd0);

    ifc.load_issue = 1; ifc.load_dest = 5'd9;
    step();
    ifc.load_issue = 0; ifc.rs_addr = 5'd9;
    ifc.mem_data = 32'h1122_3344;
    ifc.mem_size = 2'd0;
    ifc.wb_valid = 1; ifc.wb_sel = 3'd1; ifc.wb_addr = 5'd9;
    #1;
    chk("st_clr_cyc", {31'b0, ifc.stall}, {31'b0, exp_st});
    chk("byp_rd1", ifc.read_data_1, exp_rd);
    step();
    ifc.wb_valid = 0;
    #1;
    chk("st_clr_aft", {31'b0, ifc.stall}, 32'd0);
    chk("ld_r9", ifc.read_data_1, 32'h1122_3344);

    ifc.load_issue = 1; ifc.load_dest = 5'd9;
    wb(3'd1, 5'd9, 32'h0);
    ifc.load_issue = 0;
    #1;
    chk("st_setwin", {31'b0, ifc.stall}, 32'd1);
    wb(3'd1, 5'd9, 32'h0);
    #1;
    chk("st_clr2", {31'b0, ifc.stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/idecode_regfile_sb.md
Name: idecode_regfile_sb

Overview:
- Parametrised successor to the Idecode32 register-file/writeback path in the Minisys decode stage.
- Holds the general register array and the HI/LO pair, and resolves the writeback source (ALU, memory, link, HI, LO).
- Performs sub-word load extraction (lb/lbu/lh/lhu).
- Adds a load scoreboard that raises a load-use stall toward the pipeline controller.

Parameters:
- DATA_W, 32, register/data width; must be a multiple of 16, at least 32.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- LINK_REG, 31, destination forced for jal-style link writes.
- OFF_W, $clog2(DATA_W/8), byte-offset width (derived).

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- rs_addr  in  ADDR_W  read port 1 address.
- rt_addr  in  ADDR_W  read port 2 address.
- use_rs  in  1  current instruction consumes rs.
- use_rt  in  1  current instruction consumes rt.
- read_data_1  out  DATA_W  rs value.
- read_data_2  out  DATA_W  rt value.
- wb_valid  in  1  writeback this cycle.
- wb_addr  in  ADDR_W  writeback destination.
- wb_sel  in  3  source: 0 ALU, 1 MEM, 2 LINK, 3 HI, 4 LO; values 5-7 are treated as no write.
- link_ra  in  1  with wb_sel=LINK, forces the destination to LINK_REG (jal/bgezal/bltzal); otherwise wb_addr is used (jalr).
- alu_result  in  DATA_W  ALU result.
- mem_data  in  DATA_W  raw memory read word.
- mem_size  in  2  0 word, 1 half, 2 byte; 3 is treated as word.
- mem_unsigned  in  1  zero-extend the sub-word load.
- mem_byte_off  in  OFF_W  load byte offset.
- link_addr  in  DATA_W  return address (PC+4).
- hi_we  in  1  write HI (mthi / multiply-divide).
- lo_we  in  1  write LO.
- hi_wdata  in  DATA_W  HI write data.
- lo_wdata  in  DATA_W  LO write data.
- hi_out  out  DATA_W  HI register.
- lo_out  out  DATA_W  LO register.
- load_issue  in  1  a load has been issued in EX.
- load_dest  in  ADDR_W  destination of the issued load.
- stall  out  1  load-use hazard.
- write_data_out  out  DATA_W  last committed write data (registered).
- write_register_address_out  out  ADDR_W  last committed destination (registered).

Behaviour:
- Reset: at a rising edge with reset=1, the following are all cleared to 0:
  - all registers, HI and LO;
  - the busy vector;
  - write_data_out and write_register_address_out.
- Pending loads are dropped by reset; there is no residual stall on the cycle after reset.
- Register 0 reads as 0 and is never written.
- Reads are combinational from the array, i.e. zero latency.
- Destination resolution: dest = LINK_REG if (wb_sel=LINK and link_ra), else wb_addr.
- Write data by wb_sel:
  - ALU: alu_result.
  - MEM: the extracted load value.
  - LINK: link_addr.
  - HI: current HI value, before any same-cycle hi_we.
  - LO: current LO value, before any same-cycle lo_we.
- Commit happens at the rising edge when wb_valid=1, wb_sel<=4 and dest!=0. On commit, write_data_out and write_register_address_out update to the committed data and dest; otherwise they hold.
- Load extraction:
  - word: mem_data unmodified.
  - half: 16-bit lane mem_byte_off[OFF_W-1:1]; mem_byte_off[0] is ignored.
  - byte: 8-bit lane mem_byte_off; lane 0 is the LSB (little-endian).
  - Sub-words are sign-extended to DATA_W unless mem_unsigned=1.
- HI/LO: hi_we and lo_we are independent and may both be asserted in the same cycle. New values are visible on hi_out/lo_out after the edge.
- Scoreboard (NUM_REGS busy bits):
  - Set: busy[load_dest] is set at the edge when load_issue=1 and load_dest!=0.
  - Clear: busy[dest] is cleared at the edge of a committed MEM writeback.
  - Same address set and cleared in one cycle: set wins.
  - busy[0] is always 0.
- stall = (use_rs & busy[rs_addr]) | (use_rt & busy[rt_addr]); combinational.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose address equals a same-cycle committing dest (nonzero) returns the write data.
  - stall ignores a busy bit that is being cleared in the same cycle.
- Undefined:
  - Reads return the pre-edge array value.
  - stall follows the busy vector only; the stall persists through the clearing cycle.

Test Plan:
- Reset, then read rs=5, rt=31 -> read_data_1=0, read_data_2=0, hi_out=lo_out=0, stall=0.
- wb ALU to r3 with 0x1234_5678; next cycle rs=3 -> 0x12345678, write_register_address_out=3. wb to r0 with 0xFFFF_FFFF -> r0 still reads 0 and the debug outputs hold.
- mem_data=0x80FF_7F01:
  - lb off1 -> r4=0x0000007F;
  - lb off3 -> 0xFFFFFF80;
  - lbu off3 -> 0x00000080;
  - lh off2 -> 0xFFFF80FF;
  - lhu off0 -> 0x00007F01.
- hi_we with 0xAAAA_0001 and lo_we with 0x5555_0002 in the same cycle. Next cycle wb_sel=HI to r6 with hi_we=1, hi_wdata=0 -> r6=0xAAAA0001 and hi_out becomes 0.
- jal: wb_sel=LINK, link_ra=1, wb_addr=7, link_addr=0x0000_0040 -> r31=0x40, r7 unchanged. jalr: link_ra=0, wb_addr=7 -> r7=0x40.
- load_issue with dest 9, then use_rs=1, rs=9 -> stall=1. Reset during the stall -> stall=0 the next cycle.
- Repeat the scoreboard case, clearing busy[9] via a MEM wb:
  - with REGFILE_BYPASS_EN, stall=0 in the commit cycle;
  - without it, stall=1 until the following cycle.
